instr_mem_responder: RTL



---
 rtl/cicero_mem_pkg.sv | 15 +
 rtl/instr_bram.sv | 28 ++
 rtl/instr_mem_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/cicero_mem_pkg.sv
// Shared instruction-memory types for the regex engine (regex_cpu, basic_block, responder).
package cicero_mem_pkg;

  localparam int CICERO_MEM_WIDTH      = 16;
  localparam int CICERO_MEM_ADDR_WIDTH = 11;

  typedef logic [CICERO_MEM_WIDTH-1:0]      mem_word_t;
  typedef logic [CICERO_MEM_ADDR_WIDTH-1:0] mem_addr_t;

  // Round-robin successor index, wrapping to 0 after n-1.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/instr_bram.sv
// Single-port instruction RAM: one write or one read per cycle, registered read port.
// A write cycle leaves the read register untouched so the last read word stays valid.
module instr_bram #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Round-robin server of basic-block instruction fetches from one shared RAM.
// Grant in cycle t, one-cycle memory_ready pulse in t+1; host loads take priority over reads.
module instr_mem_responder
  import cicero_mem_pkg::*;
#(
  parameter int N_REQ             = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   memory_valid,
  input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic [N_REQ-1:0]                   memory_ready,
  output logic [MEMORY_WIDTH-1:0]            memory_data,
  input  logic                               load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]       load_addr,
  input  logic [MEMORY_WIDTH-1:0]            load_data,
  output logic [31:0]                        reads_served
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]             grant_q, grant_d;
  logic                         resp_v_q, resp_v_d;
  logic [31:0]                  reads_served_q, reads_served_d;

  logic [N_REQ-1:0]             inflight_mask;
  logic [N_REQ-1:0]             eligible;
  logic [N_REQ-1:0]             grant_oh;
  logic                         grant_found;
  logic [PTR_W-1:0]             grant_idx;
  logic [MEMORY_ADDR_WIDTH-1:0] grant_addr;
  logic                         issue;
  logic                         resp_fire;
  logic                         ram_we;
  logic [MEMORY_ADDR_WIDTH-1:0] ram_addr;
  logic [MEMORY_WIDTH-1:0]      ram_rdata;

  // A requester whose response is on the bus still holds valid this cycle; mask it.
  assign resp_fire     = resp_v_q & ~reset;
  assign inflight_mask = resp_fire ? grant_q : '0;
  assign eligible      = memory_valid & ~inflight_mask;

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
    grant_oh   = grant_found ? (N_REQ'(1) << grant_idx) : '0;
    grant_addr = memory_addr[int'(grant_idx)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  end

  assign issue    = grant_found & ~load_valid & ~reset;
  assign ram_we   = load_valid;
  assign ram_addr = load_valid ? load_addr : grant_addr;

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    resp_v_d       = issue;
    reads_served_d = reads_served_q;
    if (issue) begin
      grant_d  = grant_oh;
      rr_ptr_d = PTR_W'(rr_next(int'(grant_idx), N_REQ));
    end
    if (resp_fire && (reads_served_q != 32'hFFFF_FFFF)) begin
      reads_served_d = reads_served_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      resp_v_q       <= 1'b0;
      reads_served_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      resp_v_q       <= resp_v_d;
      reads_served_q <= reads_served_d;
    end
  end

  instr_bram #(
    .WIDTH      (MEMORY_WIDTH),
    .ADDR_WIDTH (MEMORY_ADDR_WIDTH)
  ) u_bram (
    .clk   (clk),
    .we    (ram_we),
    .re    (issue),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  assign memory_ready = resp_fire ? grant_q : '0;
  assign memory_data  = ram_rdata;
  assign reads_served = reads_served_q;

endmodule
